svt_link_tx: RTL

Transmit end of an SVT cable link: reads 23-bit words from an upstream FIFO and drives them onto an SVT output connector as data plus data strobe. It obeys the downstream receiver's HOLD line and applies the cable polarity encoding, so a GigaFitter mezzanine input decodes the words back to the original values. It sits behind the track-output FIFO, in the position where a Pulsar or test board feeds a mezzanine.

---
 rtl/svt_link_pkg.sv | 16 +
 rtl/svt_skid_fifo.sv | 57 +++++
 rtl/svt_link_tx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/svt_link_pkg.sv
// Shared SVT cable definitions: word width, end-event flag and polarity mask.
// The mezzanine receive path imports the same package, so the encoding lives in one place.
package svt_link_pkg;

  localparam int SVT_DATA_W = 23;
  localparam int SVT_EE_BIT = 22;
  localparam logic [SVT_DATA_W-1:0] SVT_INV_MASK = 23'h666666;

  typedef logic [SVT_DATA_W-1:0] svt_word_t;

  // Cable polarity encoding; it is its own inverse, so decode uses the same function.
  function automatic svt_word_t svt_encode(input svt_word_t word);
    return word ^ SVT_INV_MASK;
  endfunction

endpackage

// File: rtl/svt_skid_fifo.sv
// Small synchronous FIFO used as the transmit skid buffer.
// The read port is combinational; the caller registers the popped word.
module svt_skid_fifo #(
  parameter int W     = 23,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

  // Storage array; no reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/svt_link_tx.sv
// SVT link transmitter: credit-based reads from the upstream FIFO into a skid
// buffer, HOLD-gated draining onto the cable with polarity encoding and strobe.
module svt_link_tx
  import svt_link_pkg::*;
#(
  parameter int                DATA_W     = SVT_DATA_W,
  parameter int                HOLD_SYNC  = 2,
  parameter int                SKID_DEPTH = 4,
  parameter logic [DATA_W-1:0] INV_MASK   = SVT_INV_MASK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_valid,
  output logic              fifo_re,
  input  logic              hold_in,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_ds,
  output logic [15:0]       event_count,
  output logic [15:0]       hold_cycles,
  output logic              overflow_err
);

  localparam int CW = $clog2(SKID_DEPTH) + 1;

  logic [HOLD_SYNC-1:0] sync_reg;
  logic                 hold_s;
  logic                 pending_reg;
  logic                 run_reg;
  logic [CW-1:0]        count;
  logic                 empty;
  logic                 full;
  logic [DATA_W-1:0]    pop_data;
  logic                 push;
  logic                 pop;
  logic [CW:0]          inflight;
  logic [DATA_W-1:0]    tx_data_reg;
  logic                 tx_ds_reg;
  logic [15:0]          event_count_reg;
  logic [15:0]          hold_cycles_reg;
  logic                 overflow_reg;

  assign hold_s = sync_reg[HOLD_SYNC-1];

  // Words already requested (pending) count against the buffer so a read is
  // only issued when its data is guaranteed a slot. run_reg keeps reads off
  // while reset is asserted.
  assign inflight = {1'b0, count} + {{CW{1'b0}}, pending_reg};
  assign fifo_re  = run_reg & enable & ~hold_s & (inflight < (CW+1)'(SKID_DEPTH));

  assign push = fifo_valid & ~full;
  assign pop  = ~empty & ~hold_s;

  svt_skid_fifo #(
    .W     (DATA_W),
    .DEPTH (SKID_DEPTH),
    .CW    (CW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // Metastability chain on the asynchronous HOLD line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= '0;
    else        sync_reg <= {sync_reg[HOLD_SYNC-2:0], hold_in};
  end

  // Read-in-flight tracking and the post-reset run flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
      run_reg     <= 1'b0;
    end else begin
      pending_reg <= fifo_re;
      run_reg     <= 1'b1;
    end
  end

  // Cable output register: encoded word plus one-cycle strobe per pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_reg <= '0;
      tx_ds_reg   <= 1'b0;
    end else begin
      tx_ds_reg <= pop;
      if (pop) tx_data_reg <= pop_data ^ INV_MASK;
    end
  end

  // Saturating status counters and sticky overflow; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_count_reg <= '0;
      hold_cycles_reg <= '0;
      overflow_reg    <= 1'b0;
    end else if (clear) begin
      event_count_reg <= '0;
      hold_cycles_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      if (pop && pop_data[SVT_EE_BIT] && event_count_reg != 16'hFFFF)
        event_count_reg <= event_count_reg + 16'd1;
      if (hold_s && hold_cycles_reg != 16'hFFFF)
        hold_cycles_reg <= hold_cycles_reg + 16'd1;
      if (fifo_valid && full)
        overflow_reg <= 1'b1;
    end
  end

  assign tx_data      = tx_data_reg;
  assign tx_ds        = tx_ds_reg;
  assign event_count  = event_count_reg;
  assign hold_cycles  = hold_cycles_reg;
  assign overflow_err = overflow_reg;

endmodule
